// File: rtl/led_pio_pkg.sv
// Register map shared by the LED PWM PIO and anything that drives it.
package led_pio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK    = 3'd1;
  localparam logic [2:0] ADDR_OUTSET   = 3'd2;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd3;
  localparam logic [2:0] ADDR_PWMSEL   = 3'd4;
  localparam logic [2:0] ADDR_PWMDUTY  = 3'd5;
  localparam logic [2:0] ADDR_BLINKDIV = 3'd6;
endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: pending/active duty shadow pair and the PWM comparator.
module led_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                frame_end,
  input  logic                duty_wr,
  input  logic [PWM_BITS-1:0] duty_wdata,
  output logic [PWM_BITS-1:0] duty_pending,
  output logic                pwm_on
);
  logic [PWM_BITS-1:0] duty_active;

  // Active duty only changes at frame boundaries; a write landing on the boundary wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_pending <= '1;
      duty_active  <= '1;
    end else begin
      if (duty_wr)
        duty_pending <= duty_wdata;
      if (frame_end)
        duty_active <= duty_wr ? duty_wdata : duty_pending;
    end
  end

  assign pwm_on = (&duty_active) | (pwm_cnt < duty_active);
endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED port: on/off mask, set/clear, per-channel PWM brightness and blink gating.
module led_pwm_pio
  import led_pio_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 64,
  parameter int BLINK_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chipselect,
  input  logic [2:0]          address,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [CHANNELS-1:0] out_port
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic                wr_en;
  logic [CHANNELS-1:0] data_reg;
  logic [CHANNELS-1:0] blink_reg;
  logic [3:0]          pwm_sel;
  logic [BLINK_W-1:0]  blink_div;
  logic [PS_W-1:0]     presc_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_phase;
  logic                blink_eff;
  logic                tick;
  logic                frame_end;
  logic [CHANNELS-1:0] duty_wr;
  logic [CHANNELS-1:0] pwm_on;
  logic [PWM_BITS-1:0] duty_pending [CHANNELS];
  logic [PWM_BITS-1:0] sel_duty;
  logic                unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign tick      = (presc_cnt == PS_LAST);
  assign frame_end = tick & (&pwm_cnt);
  assign blink_eff = blink_phase | (blink_div == '0);
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= '0;
      blink_reg <= '0;
      pwm_sel   <= '0;
      blink_div <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data_reg  <= writedata[CHANNELS-1:0];
        ADDR_BLINK:    blink_reg <= writedata[CHANNELS-1:0];
        ADDR_OUTSET:   data_reg  <= data_reg | writedata[CHANNELS-1:0];
        ADDR_OUTCLR:   data_reg  <= data_reg & ~writedata[CHANNELS-1:0];
        ADDR_PWMSEL:   pwm_sel   <= writedata[3:0];
        ADDR_BLINKDIV: blink_div <= writedata[BLINK_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick)
        pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Blink divider counts PWM frames; a BLINKDIV write restarts the half-period but keeps the phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr_en && address == ADDR_BLINKDIV) begin
      blink_cnt <= '0;
    end else if (blink_div == '0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == blink_div - 1'b1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign duty_wr[i] = wr_en & (address == ADDR_PWMDUTY) & (pwm_sel == 4'(i));
    led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .pwm_cnt      (pwm_cnt),
      .frame_end    (frame_end),
      .duty_wr      (duty_wr[i]),
      .duty_wdata   (writedata[PWM_BITS-1:0]),
      .duty_pending (duty_pending[i]),
      .pwm_on       (pwm_on[i])
    );
  end

  // Out-of-range selections match no channel and so read back as zero.
  always_comb begin
    sel_duty = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (pwm_sel == 4'(i))
        sel_duty = duty_pending[i];
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR: readdata[CHANNELS-1:0] = data_reg;
      ADDR_BLINK:    readdata[CHANNELS-1:0] = blink_reg;
      ADDR_PWMSEL:   readdata[3:0]          = pwm_sel;
      ADDR_PWMDUTY:  readdata[PWM_BITS-1:0] = sel_duty;
      ADDR_BLINKDIV: readdata[BLINK_W-1:0]  = blink_div;
      default: ;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      out_port <= '0;
    else
      out_port <= data_reg & pwm_on & (~blink_reg | {CHANNELS{blink_eff}});
  end
endmodule

// File: tb/tb_led_pwm_pio.sv
// Scoreboard bench for led_pwm_pio: stimulus queues timed expectations, a negedge monitor checks them.
module tb_led_pwm_pio;
  import led_pio_pkg::*;
  localparam int CH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [2:0]    address = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [CH-1:0] out_port;

  led_pwm_pio #(.CHANNELS(CH), .PWM_BITS(8), .PRESCALE(1), .BLINK_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // kind 0: readdata, kind 1: out_port, kind 2: count of set out_port bits over len cycles
  typedef struct {
    int          due;
    int          kind;
    int          len;
    logic [31:0] mask;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  item_t mit;
  item_t win;
  bit    win_on = 1'b0;
  int    win_left = 0;
  int    win_cnt = 0;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  // cyc equals the number of rising edges since reset release
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_at(int due, int kind, int len, logic [31:0] mask, logic [31:0] exp, string nm);
    item_t it;
    int k;
    it.due = due; it.kind = kind; it.len = len; it.mask = mask; it.exp = exp; it.name = nm;
    k = sb.size();
    while (k > 0 && sb[k-1].due > due) k--;
    sb.insert(k, it);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mit = sb.pop_front();
      if (mit.due < cyc)
        check({mit.name, "_late"}, 32'(cyc), 32'(mit.due));
      else if (mit.kind == 0)
        check(mit.name, readdata & mit.mask, mit.exp);
      else if (mit.kind == 1)
        check(mit.name, 32'(out_port) & mit.mask, mit.exp);
      else if (win_on)
        check({mit.name, "_overlap"}, 32'd1, 32'd0);
      else begin
        win = mit; win_on = 1'b1; win_left = mit.len; win_cnt = 0;
      end
    end
    if (win_on) begin
      win_cnt += $countones(32'(out_port) & win.mask);
      win_left--;
      if (win_left == 0) begin
        check(win.name, 32'(win_cnt), win.exp);
        win_on = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(logic [2:0] a, logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(logic [2:0] a, logic [31:0] exp, string nm);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    expect_at(cyc, 0, 0, 32'hFFFF_FFFF, exp, nm);
    step();
    chipselect = 1'b0;
  endtask

  task automatic wait_mod(int r);
    while (cyc % 256 != r) step();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || win_on) && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL drain: pending=%0d want 0", sb.size());
    end
  endtask

  task automatic reset_reads(string tag);
    bus_rd(ADDR_DATA,     32'h0,  {tag, "_data"});
    bus_rd(ADDR_BLINK,    32'h0,  {tag, "_blink"});
    bus_rd(ADDR_PWMSEL,   32'h0,  {tag, "_pwmsel"});
    bus_rd(ADDR_PWMDUTY,  32'hFF, {tag, "_duty"});
    bus_rd(ADDR_BLINKDIV, 32'h0,  {tag, "_div"});
    bus_rd(3'd7,          32'h0,  {tag, "_rsvd"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int e, b, f1, f2;
    #1 reset_n = 1'b0;
    expect_at(0, 1, 0, 32'hFF, 32'h0, "rst_out");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    step();
    reset_reads("rst");

    // DATA write, one-clock output latency
    bus_wr(ADDR_DATA, 32'h01); e = cyc;
    expect_at(e,     1, 0, 32'hFF, 32'h00, "t1_out_before");
    expect_at(e + 1, 1, 0, 32'hFF, 32'h01, "t1_out_on");
    bus_rd(ADDR_DATA, 32'h01, "t1_rd");

    // OUTSET / OUTCLR
    bus_wr(ADDR_OUTSET, 32'h0C); e = cyc;
    expect_at(e,     1, 0, 32'hFF, 32'h01, "t2_set_before");
    expect_at(e + 1, 1, 0, 32'hFF, 32'h0D, "t2_set_out");
    bus_rd(ADDR_DATA,   32'h0D, "t2_set_rd");
    bus_rd(ADDR_OUTSET, 32'h0D, "t2_setaddr_rd");
    bus_wr(ADDR_OUTCLR, 32'h04); e = cyc;
    expect_at(e + 1, 1, 0, 32'hFF, 32'h09, "t2_clr_out");
    bus_rd(ADDR_OUTCLR, 32'h09, "t2_clr_rd");
    drain();

    // Duty 64 on channel 2, written mid-frame
    bus_wr(ADDR_DATA, 32'h04);
    bus_wr(ADDR_PWMSEL, 32'd2);
    bus_rd(ADDR_PWMSEL, 32'd2, "t3_sel_rd");
    wait_mod(100); b = cyc - 100;
    bus_wr(ADDR_PWMDUTY, 32'd64);
    expect_at(b + 200, 1, 0, 32'h04, 32'h04, "t3_old_duty");
    expect_at(b + 256, 1, 0, 32'h04, 32'h04, "t3_pre_frame");
    expect_at(b + 257, 1, 0, 32'h04, 32'h04, "t3_new_first");
    expect_at(b + 320, 1, 0, 32'h04, 32'h04, "t3_new_last_on");
    expect_at(b + 321, 1, 0, 32'h04, 32'h00, "t3_new_off");
    expect_at(b + 512, 2, 256, 32'h04, 32'd64, "t3_hi_count");
    bus_rd(ADDR_PWMDUTY, 32'd64, "t3_duty_rd");
    drain();

    // Duty 0 written on the frame_end edge itself, then duty 255
    wait_mod(255);
    bus_wr(ADDR_PWMDUTY, 32'd0); e = cyc;
    expect_at(e + 1, 1, 0, 32'h04, 32'h00, "t4_same_frame_load");
    expect_at(e + 1, 2, 256, 32'h04, 32'd0, "t4_zero_count");
    drain();
    bus_wr(ADDR_PWMDUTY, 32'd255); e = cyc;
    f1 = ((e + 255) / 256) * 256;
    expect_at(f1 + 1, 2, 256, 32'h04, 32'd256, "t4_full_count");
    drain();

    // Out-of-range PWMSEL
    bus_wr(ADDR_PWMSEL, 32'd12);
    bus_wr(ADDR_PWMDUTY, 32'h10);
    bus_rd(ADDR_PWMDUTY, 32'h0,  "t5_oob_rd");
    bus_rd(ADDR_PWMSEL,  32'd12, "t5_sel_rd");
    bus_wr(ADDR_PWMSEL, 32'd2);
    bus_rd(ADDR_PWMDUTY, 32'hFF, "t5_ch2_kept");
    bus_wr(ADDR_PWMSEL, 32'd4);
    bus_rd(ADDR_PWMDUTY, 32'hFF, "t5_ch4_kept");

    // Blink on channel 0 with a two-frame half-period
    bus_wr(ADDR_DATA, 32'h03);
    bus_wr(ADDR_BLINK, 32'h01);
    wait_mod(10);
    bus_wr(ADDR_BLINKDIV, 32'd2); e = cyc;
    f1 = ((e / 256) + 1) * 256;
    f2 = f1 + 256;
    bus_rd(ADDR_BLINKDIV, 32'd2, "t6_div_rd");
    bus_rd(ADDR_BLINK,    32'h1, "t6_blink_rd");
    expect_at(f1 + 1,   1, 0, 32'h03, 32'h03, "t6_one_frame");
    expect_at(f2,       1, 0, 32'h03, 32'h03, "t6_before_toggle");
    expect_at(f2 + 1,   1, 0, 32'h03, 32'h02, "t6_toggle_off");
    expect_at(f2 + 1,   2, 1024, 32'h01, 32'd512, "t6_half_count");
    expect_at(f2 + 512, 1, 0, 32'h03, 32'h02, "t6_still_off");
    expect_at(f2 + 513, 1, 0, 32'h03, 32'h03, "t6_toggle_on");
    while (cyc < f2 + 1030) step();
    bus_wr(ADDR_BLINKDIV, 32'd0); e = cyc;
    expect_at(e,     1, 0, 32'h03, 32'h02, "t6_off_before_div0");
    expect_at(e + 1, 1, 0, 32'h03, 32'h03, "t6_div0_on");
    expect_at(e + 1, 2, 600, 32'h01, 32'd600, "t6_div0_steady");
    drain();

    // Reset mid-frame with everything lit
    bus_wr(ADDR_DATA, 32'hFF); e = cyc;
    expect_at(e + 1, 1, 0, 32'hFF, 32'hFF, "t7_all_lit");
    drain();
    wait_mod(128);
    reset_n = 1'b0;
    expect_at(0, 1, 0, 32'hFF, 32'h00, "t7_rst_out");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    step();
    reset_reads("t7");

    // First frame_end lands 256 ticks after release when PRESCALE is 1
    bus_wr(ADDR_DATA, 32'h04);
    bus_wr(ADDR_PWMSEL, 32'd2);
    bus_wr(ADDR_PWMDUTY, 32'd1);
    expect_at(256, 1, 0, 32'h04, 32'h04, "t8_old_duty");
    expect_at(257, 1, 0, 32'h04, 32'h04, "t8_first_on");
    expect_at(258, 1, 0, 32'h04, 32'h00, "t8_first_off");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
